match_sequencer: RTL
====================

MATCH_SEQUENCER -- requirements
Module: match_sequencer

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 5, meaning points needed to win the match (1..15).
REQ-002 SHALL have parameter SERVE_FRAMES, default 60, meaning the hold time in frames before ball release.
REQ-003 SHALL have parameter GOAL_FRAMES, default 120, meaning the post-goal freeze time in frames.
REQ-004 SHALL have port i_clk, input, 1 bit: base clock; the only clock.
REQ-005 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_ani_stb, input, 1 bit: animation strobe, one i_clk-wide pulse per frame.
REQ-007 SHALL have port i_start, input, 1 bit: start/restart button, level, already debounced.
REQ-008 SHALL have port i_pause, input, 1 bit: pause button, level, already debounced.
REQ-009 SHALL have port i_goal_p1, input, 1 bit: ball reports a player-1 goal; one-cycle pulse.
REQ-010 SHALL have port i_goal_p2, input, 1 bit: ball reports a player-2 goal; one-cycle pulse.
REQ-011 SHALL have port o_animate, output, 1 bit: ball animate enable.
REQ-012 SHALL have port o_ball_rst, output, 1 bit: returns the ball to centre; a one-cycle pulse.
REQ-013 SHALL have port o_score_p1, output, 4 bits: player-1 score.
REQ-014 SHALL have port o_score_p2, output, 4 bits: player-2 score.
REQ-015 SHALL have port o_state, output, 3 bits: current state encoding.
REQ-016 SHALL have port o_winner, output, 2 bits: 0 = none, 1 = player 1, 2 = player 2.
REQ-017 SHALL have port o_serve_dir, output, 1 bit: 0 = serve toward player 1, 1 = serve toward player 2.

Function
REQ-018 SHALL implement the states IDLE=0, SERVE=1, PLAY=2, PAUSED=3, GOAL=4, OVER=5; encodings 6 and 7 SHALL return to IDLE on the next clock.
REQ-019 SHALL rising-edge-detect i_start and i_pause with registered copies; only edges act, so a held level has no further effect.
REQ-020 From IDLE, a start edge SHALL clear both scores, clear o_winner, pulse o_ball_rst, and enter SERVE.
REQ-021 In SERVE, o_animate SHALL be 0 and the frame counter SHALL count i_ani_stb pulses only; after SERVE_FRAMES strobes the block SHALL enter PLAY on the cycle after the last strobe.
REQ-022 In PLAY, o_animate SHALL be 1; a pause edge SHALL enter PAUSED.
REQ-023 In PAUSED, o_animate SHALL be 0; a pause edge SHALL return to PLAY; the frame counter SHALL be frozen.
REQ-024 In PLAY, a goal pulse SHALL increment the scorer's score on the same edge, set o_animate=0 from the next cycle, and enter GOAL.
REQ-025 i_goal_p1 and i_goal_p2 asserted in the same cycle SHALL credit player 1 only.
REQ-026 Goal pulses arriving in any state other than PLAY SHALL be ignored.
REQ-027 After GOAL_FRAMES strobes in GOAL, the block SHALL enter OVER with o_winner set if the scorer's score equals WIN_SCORE.
REQ-028 Otherwise, after GOAL_FRAMES strobes in GOAL, the block SHALL pulse o_ball_rst, set o_serve_dir toward the player who conceded, and enter SERVE.
REQ-029 Scores SHALL saturate at WIN_SCORE and never wrap.
REQ-030 In OVER, o_animate SHALL be 0 and scores SHALL be held; a start edge SHALL behave as the start edge from IDLE.
REQ-031 A start edge in SERVE, PLAY, PAUSED or GOAL SHALL abort the match and restart it exactly as from IDLE.
REQ-032 The start edge SHALL take priority over a same-cycle pause edge or goal pulse.
REQ-033 The frame counter SHALL clear on every state entry and SHALL be wide enough for max(SERVE_FRAMES, GOAL_FRAMES).
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 Asserting i_rst_n=0 SHALL immediately force IDLE, o_animate=0, o_ball_rst=0, both scores 0, o_winner=0, o_serve_dir=0, the frame counter to 0, and the edge registers to 0.
REQ-036 Reset asserted mid-match SHALL discard all match progress; after deassertion, the block SHALL wait in IDLE for a start edge.

Structure
REQ-037 State encodings and the o_winner codes SHALL live in the shared package pong_pkg.
REQ-038 Edge detection SHALL be one sub-module, edge_detect, instantiated twice; everything else SHALL be in a single FSM file.

Verification
REQ-039 Start edge from IDLE, SERVE_FRAMES=3 -> o_ball_rst pulses once; o_animate rises on the cycle after the 3rd strobe.
REQ-040 Goal pulse on p2 in PLAY, GOAL_FRAMES=2 -> o_score_p2=1 on the next cycle; o_animate=0; re-serve after 2 strobes with o_serve_dir=0.
REQ-041 Five goals on p1 with WIN_SCORE=5 -> o_state=OVER, o_winner=1, o_score_p1=5; a further i_goal_p1 leaves the score at 5.
REQ-042 Simultaneous goal pulses in PLAY -> only o_score_p1 increments; a goal pulse while PAUSED -> no score change.
REQ-043 Pause edge in PLAY, i_pause held for 10 cycles -> PAUSED persists; a second edge -> PLAY.
REQ-044 i_rst_n=0 during GOAL -> all outputs 0 and o_state=IDLE without waiting for a clock edge.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared match definitions: state encodings, winner codes and score helpers.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_GOAL   = 3'd4,
        ST_OVER   = 3'd5
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    // Frame counter width large enough to hold the longer of the two waits.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m + 1);
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
        return (s >= lim) ? lim : s + 4'd1;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for debounced button levels.
module edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_rise
);

    logic level_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) level_q <= 1'b0;
        else          level_q <= i_level;
    end

    assign o_rise = i_level & ~level_q;

endmodule

// File: rtl/match_sequencer.sv
// Pong match sequencer: serve hold, play, pause, goal freeze, scoring and game over.
module match_sequencer
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_FRAMES = 60,
    parameter int GOAL_FRAMES  = 120
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ani_stb,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_goal_p1,
    input  logic       i_goal_p2,
    output logic       o_animate,
    output logic       o_ball_rst,
    output logic [3:0] o_score_p1,
    output logic [3:0] o_score_p2,
    output logic [2:0] o_state,
    output logic [1:0] o_winner,
    output logic       o_serve_dir
);

    localparam int               CNT_W      = cnt_width(SERVE_FRAMES, GOAL_FRAMES);
    localparam logic [3:0]       WIN        = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] GOAL_LAST  = CNT_W'(GOAL_FRAMES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       score_p1_q, score_p1_d, score_p2_q, score_p2_d;
    logic [1:0]       winner_q, winner_d;
    logic             serve_dir_q, serve_dir_d;
    logic             animate_q, animate_d;
    logic             ball_rst_q, ball_rst_d;
    logic             scorer_q, scorer_d;   // 0: player 1 scored last, 1: player 2

    logic start_rise, pause_rise;
    logic state_valid, restart, entry, goal_any, scorer_won;

    edge_detect u_start_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_level (i_start),
        .o_rise  (start_rise)
    );

    edge_detect u_pause_edge (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_level (i_pause),
        .o_rise  (pause_rise)
    );

    assign state_valid = (state_q <= ST_OVER);
    assign restart     = start_rise & state_valid;
    assign goal_any    = i_goal_p1 | i_goal_p2;
    assign scorer_won  = scorer_q ? (score_p2_q == WIN) : (score_p1_q == WIN);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            score_p1_q  <= '0;
            score_p2_q  <= '0;
            winner_q    <= WIN_NONE;
            serve_dir_q <= 1'b0;
            animate_q   <= 1'b0;
            ball_rst_q  <= 1'b0;
            scorer_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            score_p1_q  <= score_p1_d;
            score_p2_q  <= score_p2_d;
            winner_q    <= winner_d;
            serve_dir_q <= serve_dir_d;
            animate_q   <= animate_d;
            ball_rst_q  <= ball_rst_d;
            scorer_q    <= scorer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_IDLE;
            ST_SERVE:  if (i_ani_stb && cnt_q == SERVE_LAST) state_d = ST_PLAY;
            ST_PLAY: begin
                if (goal_any)        state_d = ST_GOAL;
                else if (pause_rise) state_d = ST_PAUSED;
            end
            ST_PAUSED: if (pause_rise) state_d = ST_PLAY;
            ST_GOAL:   if (i_ani_stb && cnt_q == GOAL_LAST)
                           state_d = scorer_won ? ST_OVER : ST_SERVE;
            ST_OVER:   state_d = ST_OVER;
            default:   state_d = ST_IDLE;
        endcase
        if (restart) state_d = ST_SERVE;
    end

    // Outputs are computed from the next state so they change together with o_state.
    always_comb begin
        score_p1_d  = score_p1_q;
        score_p2_d  = score_p2_q;
        winner_d    = winner_q;
        serve_dir_d = serve_dir_q;
        scorer_d    = scorer_q;
        ball_rst_d  = 1'b0;
        animate_d   = (state_d == ST_PLAY);
        entry       = restart || (state_d != state_q);

        if (restart) begin
            score_p1_d = '0;
            score_p2_d = '0;
            winner_d   = WIN_NONE;
            ball_rst_d = 1'b1;
        end else if (state_q == ST_PLAY) begin
            if (i_goal_p1) begin
                score_p1_d = sat_inc(score_p1_q, WIN);
                scorer_d   = 1'b0;
            end else if (i_goal_p2) begin
                score_p2_d = sat_inc(score_p2_q, WIN);
                scorer_d   = 1'b1;
            end
        end else if (state_q == ST_GOAL) begin
            if (state_d == ST_OVER) begin
                winner_d = scorer_q ? WIN_P2 : WIN_P1;
            end else if (state_d == ST_SERVE) begin
                ball_rst_d  = 1'b1;
                serve_dir_d = ~scorer_q;
            end
        end

        cnt_d = cnt_q;
        if (entry)
            cnt_d = '0;
        else if (i_ani_stb && (state_q == ST_SERVE || state_q == ST_GOAL))
            cnt_d = cnt_q + 1'b1;
    end

    assign o_state     = state_q;
    assign o_animate   = animate_q;
    assign o_ball_rst  = ball_rst_q;
    assign o_score_p1  = score_p1_q;
    assign o_score_p2  = score_p2_q;
    assign o_winner    = winner_q;
    assign o_serve_dir = serve_dir_q;

endmodule
